regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2: entries per requester FIFO, power of two, 2..8.
REQ-002 SHALL have parameter CNT_W, default 16: width of the conflict counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port aValid, input, 1 bit: requester A (ALU writeback) offers a write.
REQ-006 SHALL have port aReady, output, 1 bit: FIFO A can accept.
REQ-007 SHALL have port aDest, input, 5 bits: destination register index for A.
REQ-008 SHALL have port aData, input, 32 bits: write data for A.
REQ-009 SHALL have ports bValid, bReady, bDest and bData: requester B (load writeback), same widths and meanings as the A ports.
REQ-010 SHALL have port regDest, output, 5 bits: register file write index.
REQ-011 SHALL have port writeData, output, 32 bits: register file write data.
REQ-012 SHALL have port regWrite, output, 1 bit: register file write enable.
REQ-013 SHALL have port pending, output, 32 bits: registers with a write queued or in flight.
REQ-014 SHALL have port conflictCnt, output, CNT_W bits: count of cycles in which both FIFO heads were valid.

Function
REQ-015 SHALL accept a request on a port at a rising edge when Valid and Ready are both 1, pushing {Dest, Data} into that port's FIFO.
REQ-016 SHALL drive Ready = (FIFO count < DEPTH) only; a full FIFO SHALL NOT accept a push, even in a cycle where it pops (no bypass).
REQ-017 SHALL make a pushed entry eligible for arbitration only from the cycle after the push; input-to-output has no combinational path.
REQ-018 SHALL, each cycle, select at most one FIFO head: if only one FIFO is non-empty, select it; if both are, select the port named by rrPtr (0=A, 1=B).
REQ-019 SHALL, on every grant, pop the selected head and set rrPtr to the non-granted port; rrPtr SHALL hold when there is no grant.
REQ-020 SHALL register the output stage: at the edge of a grant, load regDest/writeData from the head, and set regWrite=1 if head Dest != 0.
REQ-021 SHALL, when the granted head has Dest == 0, pop it, drive regWrite=0 for that cycle, and hold regDest/writeData.
REQ-022 SHALL drive regWrite=0 and hold regDest/writeData in any cycle following an edge with no grant.
REQ-023 SHALL give a minimum latency of 1 clock from acceptance edge to regWrite high; sustained throughput 1 write/clock.
REQ-024 SHALL set pending[i], i in 1..31, combinationally when any valid FIFO entry has Dest == i or (regWrite==1 and regDest == i); pending[0] SHALL always be 0.
REQ-025 SHALL increment conflictCnt at each edge where both FIFOs are non-empty, saturating at all-ones.
REQ-026 SHALL preserve per-port order; no ordering is guaranteed between ports.
REQ-027 SHALL wrap FIFO read and write pointers modulo DEPTH; count range 0..DEPTH.

Reset
REQ-028 SHALL, while rst=1, asynchronously clear FIFO pointers and counts, rrPtr=0, regWrite=0, regDest=0, writeData=0, and conflictCnt=0; aReady=bReady=1 after release.
REQ-029 SHALL discard all queued and in-flight writes on reset mid-operation; pending SHALL read 0 while rst=1.

Verification
REQ-030 SHALL pass: A pushes Dest=2, Data=5 alone -> one cycle later regWrite=1, regDest=2, writeData=5; pending[2]=1 from the push edge until regWrite drops.
REQ-031 SHALL pass: A(Dest=3, Data=0x11) and B(Dest=4, Data=0x22) pushed on the same edge after reset -> A written first, then B; conflictCnt=1.
REQ-032 SHALL pass: with A and B each holding 3 requests presented continuously at DEPTH=2 -> grants alternate A,B,A,B,A,B; aReady drops while A is full.
REQ-033 SHALL pass: B pushes Dest=0, Data=0xFF -> entry popped, regWrite stays 0, pending stays 0.
REQ-034 SHALL pass: rst asserted mid-burst with 2 entries queued -> regWrite=0 immediately; no write occurs after release; conflictCnt=0.
REQ-035 SHALL pass: with CNT_W=2, both FIFOs kept non-empty for 5 cycles -> conflictCnt saturates at 3.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Brief    : Two-requester register-file writeback arbiter. Each requester
//            (A = ALU, B = load) has a small FIFO. Non-empty FIFO heads are
//            granted round-robin into a registered write port. The block also
//            reports which registers have writes queued or in flight, and
//            counts cycles in which both heads competed.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  // Requester A (ALU writeback)
  input  logic             aValid,
  output logic             aReady,
  input  logic [4:0]       aDest,
  input  logic [31:0]      aData,
  // Requester B (load writeback)
  input  logic             bValid,
  output logic             bReady,
  input  logic [4:0]       bDest,
  input  logic [31:0]      bData,
  // Register file write port
  output logic [4:0]       regDest,
  output logic [31:0]      writeData,
  output logic             regWrite,
  // Status
  output logic [31:0]      pending,
  output logic [CNT_W-1:0] conflictCnt
);

  localparam int                AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CW        = AW + 1;
  localparam logic [CW-1:0]     C_DEPTH   = CW'(DEPTH);
  localparam logic [CNT_W-1:0]  C_CNT_MAX = '1;

  // FIFO A storage and bookkeeping
  logic [4:0]    r_a_dest [DEPTH];
  logic [31:0]   r_a_data [DEPTH];
  logic [AW-1:0] r_a_wp;
  logic [AW-1:0] r_a_rp;
  logic [CW-1:0] r_a_cnt;

  // FIFO B storage and bookkeeping
  logic [4:0]    r_b_dest [DEPTH];
  logic [31:0]   r_b_data [DEPTH];
  logic [AW-1:0] r_b_wp;
  logic [AW-1:0] r_b_rp;
  logic [CW-1:0] r_b_cnt;

  // Arbitration and output stage state
  logic             r_rr_ptr;       // 0 = A preferred, 1 = B preferred
  logic [4:0]       r_reg_dest;
  logic [31:0]      r_write_data;
  logic             r_reg_write;
  logic [CNT_W-1:0] r_conflict_cnt;

  // Handshake and arbitration wires
  logic          w_a_ready;
  logic          w_b_ready;
  logic          w_a_push;
  logic          w_b_push;
  logic          w_a_ne;
  logic          w_b_ne;
  logic          w_gnt_a;
  logic          w_gnt_b;
  logic          w_gnt;
  logic [4:0]    w_head_dest;
  logic [31:0]   w_head_data;
  logic [31:0]   w_pending;

  // Ready depends only on occupancy: a full FIFO never accepts, even while popping
  assign w_a_ready = (r_a_cnt < C_DEPTH);
  assign w_b_ready = (r_b_cnt < C_DEPTH);
  assign w_a_push  = aValid & w_a_ready;
  assign w_b_push  = bValid & w_b_ready;

  assign w_a_ne = (r_a_cnt != '0);
  assign w_b_ne = (r_b_cnt != '0);

  // A sole non-empty FIFO wins outright; a tie goes to the round-robin favourite
  assign w_gnt_a = w_a_ne & (~w_b_ne | ~r_rr_ptr);
  assign w_gnt_b = w_b_ne & (~w_a_ne |  r_rr_ptr);
  assign w_gnt   = w_gnt_a | w_gnt_b;

  assign w_head_dest = w_gnt_a ? r_a_dest[r_a_rp] : r_b_dest[r_b_rp];
  assign w_head_data = w_gnt_a ? r_a_data[r_a_rp] : r_b_data[r_b_rp];

  // FIFO payload storage; contents are meaningless outside the valid window
  always_ff @(posedge clk) begin
    if (w_a_push) begin
      r_a_dest[r_a_wp] <= aDest;
      r_a_data[r_a_wp] <= aData;
    end
    if (w_b_push) begin
      r_b_dest[r_b_wp] <= bDest;
      r_b_data[r_b_wp] <= bData;
    end
  end

  // FIFO A pointers and occupancy; pointers wrap naturally at power-of-two DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_wp  <= '0;
      r_a_rp  <= '0;
      r_a_cnt <= '0;
    end else begin
      if (w_a_push) r_a_wp <= r_a_wp + 1'b1;
      if (w_gnt_a)  r_a_rp <= r_a_rp + 1'b1;
      case ({w_a_push, w_gnt_a})
        2'b10:   r_a_cnt <= r_a_cnt + 1'b1;
        2'b01:   r_a_cnt <= r_a_cnt - 1'b1;
        default: r_a_cnt <= r_a_cnt;
      endcase
    end
  end

  // FIFO B pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b_wp  <= '0;
      r_b_rp  <= '0;
      r_b_cnt <= '0;
    end else begin
      if (w_b_push) r_b_wp <= r_b_wp + 1'b1;
      if (w_gnt_b)  r_b_rp <= r_b_rp + 1'b1;
      case ({w_b_push, w_gnt_b})
        2'b10:   r_b_cnt <= r_b_cnt + 1'b1;
        2'b01:   r_b_cnt <= r_b_cnt - 1'b1;
        default: r_b_cnt <= r_b_cnt;
      endcase
    end
  end

  // Round-robin pointer moves to the loser on every grant, holds otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= 1'b0;
    end else if (w_gnt) begin
      r_rr_ptr <= w_gnt_a;
    end
  end

  // Registered write port; writes to r0 are consumed silently and data is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg_dest   <= '0;
      r_write_data <= '0;
      r_reg_write  <= 1'b0;
    end else if (w_gnt && (w_head_dest != 5'd0)) begin
      r_reg_dest   <= w_head_dest;
      r_write_data <= w_head_data;
      r_reg_write  <= 1'b1;
    end else begin
      r_reg_write  <= 1'b0;
    end
  end

  // Saturating count of edges where both heads were competing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_conflict_cnt <= '0;
    end else if (w_a_ne && w_b_ne && (r_conflict_cnt != C_CNT_MAX)) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  // Scoreboard of registers with a queued or in-flight write; r0 never pending
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, AW'(i) - r_a_rp} < r_a_cnt) w_pending[r_a_dest[i]] = 1'b1;
      if ({1'b0, AW'(i) - r_b_rp} < r_b_cnt) w_pending[r_b_dest[i]] = 1'b1;
    end
    if (r_reg_write) w_pending[r_reg_dest] = 1'b1;
    w_pending[0] = 1'b0;
  end

  assign aReady      = w_a_ready;
  assign bReady      = w_b_ready;
  assign regDest     = r_reg_dest;
  assign writeData   = r_write_data;
  assign regWrite    = r_reg_write;
  assign pending     = w_pending;
  assign conflictCnt = r_conflict_cnt;

endmodule
`default_nettype wire
